// File: rtl/sphn_pong_pkg.sv
// Shared types, default parameters and helpers for the pong paddle controller.
// Imported by the per-player axis and the top-level controller.
package sphn_pong_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEL  = 2'd1,
        ST_CRUISE = 2'd2
    } axis_state_e;

    localparam int DEF_NUM_PLAYERS  = 2;
    localparam int DEF_Y_WIDTH      = 10;
    localparam int DEF_SCREEN_H     = 480;
    localparam int DEF_PADDLE_H     = 64;
    localparam int DEF_MAX_SPEED    = 8;
    localparam int DEF_ACCEL_FRAMES = 4;
    localparam int DEF_AI_SPEED     = 3;

    function automatic int centre_pos(input int screen_h, input int paddle_h);
        return (screen_h - paddle_h) / 2;
    endfunction

endpackage

// File: rtl/sphn_paddle_axis.sv
// One paddle: input synchroniser, IDLE/ACCEL/CRUISE speed machine, AI tracker
// and clamped position register. All state advances only on frame ticks.
module sphn_paddle_axis
    import sphn_pong_pkg::*;
#(
    parameter int Y_WIDTH      = DEF_Y_WIDTH,
    parameter int SCREEN_H     = DEF_SCREEN_H,
    parameter int PADDLE_H     = DEF_PADDLE_H,
    parameter int MAX_SPEED    = DEF_MAX_SPEED,
    parameter int ACCEL_FRAMES = DEF_ACCEL_FRAMES,
    parameter int AI_SPEED     = DEF_AI_SPEED
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic               up,
    input  logic               down,
    input  logic               human,
    input  logic [Y_WIDTH-1:0] ball_y,
    output logic [Y_WIDTH-1:0] paddle_y,
    output logic               moving
);

    localparam int PW    = Y_WIDTH + 2;
    localparam int SPD_W = $clog2(MAX_SPEED + 1);
    localparam int CNT_W = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;

    typedef logic signed [PW-1:0] spos_t;

    localparam spos_t              Y_MAX    = spos_t'(SCREEN_H - PADDLE_H);
    localparam spos_t              HALF_H   = spos_t'(PADDLE_H / 2);
    localparam spos_t              AI_STEP  = spos_t'(AI_SPEED);
    localparam logic [Y_WIDTH-1:0] Y_CENTRE = Y_WIDTH'(centre_pos(SCREEN_H, PADDLE_H));
    localparam logic [SPD_W-1:0]   SPD_ONE  = SPD_W'(1);
    localparam logic [SPD_W-1:0]   SPD_MAX  = SPD_W'(MAX_SPEED);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(ACCEL_FRAMES - 1);
    localparam axis_state_e        ENTRY_ST = (MAX_SPEED > 1) ? ST_ACCEL : ST_CRUISE;

    function automatic logic [Y_WIDTH-1:0] clamp_pos(input spos_t v);
        spos_t c;
        if (v < spos_t'(0)) begin
            c = spos_t'(0);
        end else if (v > Y_MAX) begin
            c = Y_MAX;
        end else begin
            c = v;
        end
        return c[Y_WIDTH-1:0];
    endfunction

    logic [2:0]         meta_r, sync_r;
    logic               up_s, down_s, human_s;
    axis_state_e        state_r, state_s;
    logic [SPD_W-1:0]   speed_r, speed_s, speed_inc_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic               dir_up_r, dir_up_s;
    logic               mode_r, mode_s;
    logic [Y_WIDTH-1:0] pos_r, pos_nxt_s;
    logic               moving_r;
    spos_t              pos_ext_s, target_s, diff_s, delta_s;

    assign up_s    = sync_r[0];
    assign down_s  = sync_r[1];
    assign human_s = sync_r[2];

    // Two-flop synchroniser for the asynchronous buttons and mode select
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 3'b000;
            sync_r <= 3'b000;
        end else begin
            meta_r <= {human, down, up};
            sync_r <= meta_r;
        end
    end

    // Next speed/state and signed position step for the coming frame tick
    always_comb begin
        state_s     = state_r;
        speed_s     = speed_r;
        cnt_s       = cnt_r;
        dir_up_s    = dir_up_r;
        mode_s      = mode_r;
        delta_s     = spos_t'(0);
        speed_inc_s = speed_r + SPD_ONE;
        pos_ext_s   = spos_t'({2'b00, pos_r});
        target_s    = spos_t'({2'b00, clamp_pos(spos_t'({2'b00, ball_y}) - HALF_H)});
        diff_s      = target_s - pos_ext_s;
        if (human_s != mode_r) begin
            // Mode switch costs one tick: everything parks before the new mode acts
            mode_s  = human_s;
            state_s = ST_IDLE;
            speed_s = '0;
            cnt_s   = '0;
        end else if (mode_r) begin
            if (up_s == down_s) begin
                state_s = ST_IDLE;
                speed_s = '0;
                cnt_s   = '0;
            end else if ((state_r == ST_IDLE) || (up_s != dir_up_r)) begin
                state_s  = ENTRY_ST;
                speed_s  = SPD_ONE;
                cnt_s    = '0;
                dir_up_s = up_s;
            end else if (state_r == ST_ACCEL) begin
                if (cnt_r == CNT_LAST) begin
                    speed_s = speed_inc_s;
                    cnt_s   = '0;
                    state_s = (speed_inc_s >= SPD_MAX) ? ST_CRUISE : ST_ACCEL;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end else begin
                state_s = ST_CRUISE;
                speed_s = SPD_MAX;
            end
            if (up_s != down_s) begin
                delta_s = up_s ? -spos_t'(speed_s) : spos_t'(speed_s);
            end else begin
                delta_s = spos_t'(0);
            end
        end else begin
            state_s = ST_IDLE;
            speed_s = '0;
            cnt_s   = '0;
            if ((diff_s <= AI_STEP) && (diff_s >= -AI_STEP)) begin
                delta_s = diff_s;
            end else if (diff_s < spos_t'(0)) begin
                delta_s = -AI_STEP;
            end else begin
                delta_s = AI_STEP;
            end
        end
        pos_nxt_s = clamp_pos(pos_ext_s + delta_s);
    end

    // Frame-tick state update and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            speed_r  <= '0;
            cnt_r    <= '0;
            dir_up_r <= 1'b0;
            mode_r   <= 1'b0;
            pos_r    <= Y_CENTRE;
            moving_r <= 1'b0;
        end else if (frame_tick) begin
            state_r  <= state_s;
            speed_r  <= speed_s;
            cnt_r    <= cnt_s;
            dir_up_r <= dir_up_s;
            mode_r   <= mode_s;
            pos_r    <= pos_nxt_s;
            moving_r <= (pos_nxt_s != pos_r);
        end
    end

    assign paddle_y = pos_r;
    assign moving   = moving_r;

endmodule

// File: rtl/sphn_paddle_ctrl.sv
// Pong paddle controller: one independent sphn_paddle_axis per player,
// outputs packed player-major into o_paddle_y.
module sphn_paddle_ctrl
    import sphn_pong_pkg::*;
#(
    parameter int NUM_PLAYERS  = DEF_NUM_PLAYERS,
    parameter int Y_WIDTH      = DEF_Y_WIDTH,
    parameter int SCREEN_H     = DEF_SCREEN_H,
    parameter int PADDLE_H     = DEF_PADDLE_H,
    parameter int MAX_SPEED    = DEF_MAX_SPEED,
    parameter int ACCEL_FRAMES = DEF_ACCEL_FRAMES,
    parameter int AI_SPEED     = DEF_AI_SPEED
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_frame_tick,
    input  logic [NUM_PLAYERS-1:0]         i_up,
    input  logic [NUM_PLAYERS-1:0]         i_down,
    input  logic [NUM_PLAYERS-1:0]         i_human,
    input  logic [Y_WIDTH-1:0]             i_ball_y,
    output logic [NUM_PLAYERS*Y_WIDTH-1:0] o_paddle_y,
    output logic [NUM_PLAYERS-1:0]         o_moving
);

    genvar k;
    generate
        for (k = 0; k < NUM_PLAYERS; k++) begin : g_axis
            sphn_paddle_axis #(
                .Y_WIDTH      (Y_WIDTH),
                .SCREEN_H     (SCREEN_H),
                .PADDLE_H     (PADDLE_H),
                .MAX_SPEED    (MAX_SPEED),
                .ACCEL_FRAMES (ACCEL_FRAMES),
                .AI_SPEED     (AI_SPEED)
            ) u_axis (
                .clk        (clk),
                .rst_n      (rst_n),
                .frame_tick (i_frame_tick),
                .up         (i_up[k]),
                .down       (i_down[k]),
                .human      (i_human[k]),
                .ball_y     (i_ball_y),
                .paddle_y   (o_paddle_y[k*Y_WIDTH +: Y_WIDTH]),
                .moving     (o_moving[k])
            );
        end
    endgenerate

endmodule

// File: tb/tb_sphn_paddle_ctrl.sv
// Scoreboard bench for sphn_paddle_ctrl: directed scenarios plus random
// button/mode/ball traffic checked against a held-ticks reference model.
module tb_sphn_paddle_ctrl;

    localparam int NP   = 2;
    localparam int YW   = 10;
    localparam int SH   = 480;
    localparam int PH   = 64;
    localparam int MS   = 8;
    localparam int AF   = 4;
    localparam int AIS  = 3;
    localparam int YMAX = SH - PH;
    localparam int CTR  = (SH - PH) / 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             tick;
    logic [NP-1:0]    up, down, human;
    logic [YW-1:0]    ball;
    logic [NP*YW-1:0] paddle;
    logic [NP-1:0]    moving;

    typedef struct packed {
        logic [NP*YW-1:0] y;
        logic [NP-1:0]    mv;
        logic [NP*YW-1:0] pre;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: position, held direction (0 none, 1 up, 2 down),
    // number of consecutive held ticks, applied mode.
    int   m_pos[NP];
    int   m_dir[NP];
    int   m_held[NP];
    bit   m_mode[NP];

    sphn_paddle_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_frame_tick (tick),
        .i_up         (up),
        .i_down       (down),
        .i_human      (human),
        .i_ball_y     (ball),
        .o_paddle_y   (paddle),
        .o_moving     (moving)
    );

    always #5 clk = ~clk;

    function automatic int clampi(input int v);
        if (v < 0) return 0;
        if (v > YMAX) return YMAX;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int py(input int k);
        return int'(paddle[k*YW +: YW]);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NP; k++) begin
            m_pos[k] = CTR; m_dir[k] = 0; m_held[k] = 0; m_mode[k] = 1'b0;
        end
    endtask

    // Let inputs settle through the synchroniser, predict, then pulse one tick
    task automatic do_tick();
        exp_t e;
        int   old, nw, d, spd, tgt, diff;
        repeat (3) @(negedge clk);
        e.pre = paddle;
        for (int k = 0; k < NP; k++) begin
            old = m_pos[k];
            nw  = old;
            if (human[k] != m_mode[k]) begin
                m_mode[k] = human[k]; m_dir[k] = 0; m_held[k] = 0;
            end else if (m_mode[k]) begin
                d = (up[k] ^ down[k]) ? (up[k] ? 1 : 2) : 0;
                if (d == 0) begin
                    m_dir[k] = 0; m_held[k] = 0;
                end else begin
                    if (d != m_dir[k]) begin
                        m_dir[k] = d; m_held[k] = 1;
                    end else begin
                        m_held[k]++;
                    end
                    spd = 1 + (m_held[k] - 1) / AF;
                    if (spd > MS) spd = MS;
                    nw = clampi(old + ((d == 1) ? -spd : spd));
                end
            end else begin
                tgt  = clampi(int'(ball) - PH / 2);
                diff = tgt - old;
                if (diff <= AIS && diff >= -AIS) nw = tgt;
                else nw = old + ((diff > 0) ? AIS : -AIS);
            end
            m_pos[k] = nw;
            e.y[k*YW +: YW] = nw[YW-1:0];
            e.mv[k] = (nw != old);
        end
        q.push_back(e);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < NP; k++) chk("reset_pos", py(k), CTR);
        chk("reset_moving", int'(moving), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Monitor: every sampled tick yields one updated output to compare
    initial begin
        exp_t e;
        int   dlt;
        forever begin
            @(posedge clk);
            if (tick === 1'b1) begin
                @(negedge clk);
                if (q.size() == 0) begin
                    chk("scoreboard_underflow", 1, 0);
                end else begin
                    e = q.pop_front();
                    checks++;
                    if (paddle !== e.y || moving !== e.mv) begin
                        errors++;
                        $display("FAIL tick_compare: got y=%h mv=%b expected y=%h mv=%b at %0t",
                                 paddle, moving, e.y, e.mv, $time);
                    end
                    for (int k = 0; k < NP; k++) begin
                        dlt = py(k) - int'(e.pre[k*YW +: YW]);
                        if (dlt < 0) dlt = -dlt;
                        checks++;
                        if (dlt > MS) begin
                            errors++;
                            $display("FAIL speed_bound: player %0d moved %0d lines, limit %0d", k, dlt, MS);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; tick = 1'b0; up = '0; down = '0; human = '0; ball = '0;
        model_reset();
        apply_reset();

        // Reset then no ticks: centred and idle
        repeat (5) @(negedge clk);
        chk("idle_p0", py(0), CTR);
        chk("idle_p1", py(1), CTR);
        chk("idle_moving", int'(moving), 0);

        // Player 0 human holding up; player 1 AI parked at its own target
        ball = 10'd240; human = 2'b01; up = 2'b01; down = 2'b00;
        do_tick();
        for (int i = 1; i <= 41; i++) begin
            do_tick();
            if (i <= 4) chk("up_hold_early", py(0), CTR - i);
            if (i == 8) chk("up_hold_tick8", py(0), 196);
            if (i == 41) begin
                chk("up_clamp_top", py(0), 0);
                chk("up_clamp_moving", int'(moving[0]), 0);
            end
        end

        // Both buttons: no press, then a fresh press starts at speed 1
        up = 2'b01; down = 2'b01;
        do_tick();
        chk("both_no_move", py(0), 0);
        chk("both_moving", int'(moving[0]), 0);
        up = 2'b00; down = 2'b01;
        do_tick();
        chk("after_both_first_step", py(0), 1);

        // Player 1 switches to buttons and holds down to the bottom
        up = 2'b00; down = 2'b10; human = 2'b11;
        do_tick();
        for (int i = 1; i <= 60; i++) do_tick();
        chk("down_clamp_bottom", py(1), YMAX);
        chk("down_clamp_moving", int'(moving[1]), 0);

        // AI tracking from centre towards ball at 100
        apply_reset();
        human = 2'b00; up = 2'b00; down = 2'b00; ball = 10'd100;
        for (int i = 1; i <= 50; i++) begin
            do_tick();
            if (i == 1) chk("ai_first_step", py(1), CTR - AIS);
            if (i == 46) chk("ai_tick46", py(1), 70);
            if (i == 47) chk("ai_tick47", py(1), 68);
            if (i == 50) begin
                chk("ai_settled", py(1), 68);
                chk("ai_settled_moving", int'(moving[1]), 0);
            end
        end

        // Reversal after 6 up ticks, then reset mid-hold
        apply_reset();
        ball = 10'd240; human = 2'b01; up = 2'b01; down = 2'b00;
        do_tick();
        for (int i = 1; i <= 6; i++) do_tick();
        chk("up6_pos", py(0), 200);
        up = 2'b00; down = 2'b01;
        do_tick();
        chk("reversal_first_step", py(0), 201);
        do_tick();
        do_tick();
        apply_reset();
        do_tick();
        do_tick();
        chk("post_reset_speed1", py(0), CTR + 1);

        // Random traffic against the reference model
        apply_reset();
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 5) == 0) up = 2'($urandom);
            if ($urandom_range(0, 5) == 0) down = 2'($urandom);
            if ($urandom_range(0, 24) == 0) human = 2'($urandom);
            if ($urandom_range(0, 3) == 0) ball = 10'($urandom);
            do_tick();
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sphn_paddle_ctrl.md
SPHN_PADDLE_CTRL -- requirements
Module: sphn_paddle_ctrl

Interface
REQ-001 SHALL have parameter NUM_PLAYERS, default 2: number of independent paddles.
REQ-002 SHALL have parameter Y_WIDTH, default 10: paddle and ball vertical coordinate width.
REQ-003 SHALL have parameter SCREEN_H, default 480: visible lines.
REQ-004 SHALL have parameter PADDLE_H, default 64: paddle height in lines.
REQ-005 SHALL have parameter MAX_SPEED, default 8: human speed ceiling in lines/frame.
REQ-006 SHALL have parameter ACCEL_FRAMES, default 4: frames held per speed step.
REQ-007 SHALL have parameter AI_SPEED, default 3: AI speed in lines/frame.
REQ-008 SHALL use one clock and an asynchronous, active-low reset; ports are listed below.
- clk  in  1  pixel clock
- rst_n  in  1  async active-low reset
- i_frame_tick  in  1  one-cycle pulse per frame (vblank start)
- i_up  in  NUM_PLAYERS  async up button per player
- i_down  in  NUM_PLAYERS  async down button per player
- i_human  in  NUM_PLAYERS  async mode per player: 1 = buttons, 0 = AI
- i_ball_y  in  Y_WIDTH  ball top coordinate, synchronous to clk
- o_paddle_y  out  NUM_PLAYERS*Y_WIDTH  paddle top; player k at [k*Y_WIDTH +: Y_WIDTH]
- o_moving  out  NUM_PLAYERS  paddle moved on last update

Function
REQ-009 SHALL pass i_up, i_down and i_human through a two-flop synchroniser per bit before any use.
REQ-010 SHALL change state only on cycles with i_frame_tick=1; registered outputs update on that edge and are visible the following cycle.
REQ-011 SHALL run a per-player state machine with states IDLE, ACCEL and CRUISE.
- IDLE: speed 0.
- IDLE to ACCEL on a valid press: speed becomes 1 and the paddle moves 1 on that tick.
- ACCEL: speed increments after every ACCEL_FRAMES consecutive held ticks.
- ACCEL to CRUISE when speed reaches MAX_SPEED; CRUISE holds MAX_SPEED.
REQ-012 SHALL treat up and down both asserted, or neither asserted, as no press: state IDLE, speed 0, no move.
REQ-013 SHALL, on a direction reversal, restart at speed 1 in ACCEL with the frame counter cleared.
REQ-014 SHALL compute the next position in Y_WIDTH+2-bit signed arithmetic and clamp it to [0, SCREEN_H-PADDLE_H]; the position never wraps.
REQ-015 SHALL, in AI mode, track target = clamp(i_ball_y - PADDLE_H/2, 0, SCREEN_H-PADDLE_H).
- If |target - pos| <= AI_SPEED, pos takes target exactly.
- Otherwise pos steps AI_SPEED toward target.
- i_up and i_down are ignored in AI mode.
REQ-016 SHALL, on any i_human change, clear speed and the frame counter and enter IDLE on the next tick before applying the new mode.
REQ-017 SHALL assert o_moving[k] exactly when player k's position changed at the last tick.
REQ-018 SHALL keep players fully independent; simultaneous events on different players never interact.

Reset
REQ-019 SHALL, while rst_n=0, hold every o_paddle_y field at (SCREEN_H-PADDLE_H)/2 (208 at defaults), o_moving at 0, speed 0, frame counter 0, state IDLE and synchronisers at 0.
REQ-020 SHALL abandon any in-progress acceleration on a reset asserted mid-frame, with no residual speed after release.

Structure
REQ-021 SHALL place the state enum, default parameter values and the centre-position function in package sphn_pong_pkg.
REQ-022 SHALL instantiate one sub-module, sphn_paddle_axis, per player via a generate loop; it contains that player's state machine, counter, clamp and AI logic.

Verification
REQ-023 SHALL check reset, then no ticks: every o_paddle_y field is 208 and o_moving is 0.
REQ-024 SHALL check player 0 holding up with i_human=1: positions 207, 206, 205, 204 after ticks 1-4, 196 after tick 8, then clamped at 0 with o_moving[0]=0.
REQ-025 SHALL check player 1 holding down for 60 ticks: position saturates at 416 and speed never exceeds 8 lines/frame.
REQ-026 SHALL check both buttons asserted on player 0: no move, and state returns to IDLE.
REQ-027 SHALL check player 1 in AI mode with i_ball_y=100 from 208: decrements by 3 per tick, reaches exactly 68 on tick 47, then stays at 68.
REQ-028 SHALL check up held for 6 ticks, then down: the first down tick moves +1; and rst_n pulsed mid-hold returns the position to 208 and speed to 0.
